sound_arbiter: RTL and testbench
================================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, max cycles a grant may stay in START+PLAY before forced termination.
REQ-002 SHALL have parameter ACK_CYCLES, default 8'd16, max cycles in START waiting for snd_over to fall.
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req  in  4  per-requester note request; bit0 = system beep, bits1..3 = free/auto/play/study mode players.
REQ-006 SHALL have port note_i  in  12  packed 3-bit note per requester, requester k at [3k+2:3k].
REQ-007 SHALL have port oct_i  in  12  packed 3-bit octave per requester.
REQ-008 SHALL have port len_i  in  12  packed 3-bit length code per requester.
REQ-009 SHALL have port snd_over  in  1  tone generator status; 1 = idle/finished, 0 = playing.
REQ-010 SHALL have port gnt  out  4  one-hot current owner, or 0.
REQ-011 SHALL have port done  out  4  one-cycle completion pulse to owner.
REQ-012 SHALL have port err  out  1  one-cycle pulse on timeout termination.
REQ-013 SHALL have port snd_en  out  1  tone generator enable.
REQ-014 SHALL have ports snd_note, snd_oct, snd_len  out  3 each  latched fields of owner.
REQ-015 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE, START, PLAY, DONE.
REQ-017 IDLE: if any req bit set, SHALL pick winner, latch its note/oct/len, set gnt one-hot and snd_en=1 on the next edge, enter START; latency req->gnt = 1 cycle.
REQ-018 Arbitration SHALL give req[0] strict priority; among req[1..3] round-robin starting at the index after the last granted of 1..3 (pointer resets to 1).
REQ-019 Round-robin pointer SHALL advance only on done or err, never on abort.
REQ-020 START: snd_en=1; on snd_over==0 SHALL enter PLAY; if ACK_CYCLES elapse first, SHALL go to DONE with err.
REQ-021 PLAY: snd_en=1 until snd_over==1 observed, then SHALL enter DONE.
REQ-022 DONE: snd_en=0, gnt=0, done[owner]=1 for exactly one cycle (err=1 instead of done if timeout); next state IDLE.
REQ-023 Watchdog counter SHALL clear on grant, count in START and PLAY, saturate; on reaching TIMEOUT_CYCLES SHALL go to DONE with err and no done pulse.
REQ-024 If owner drops req during START/PLAY, SHALL abort: next edge gnt=0, snd_en=0, no done/err, state IDLE.
REQ-025 Latched snd_note/oct/len SHALL hold while owned; changes on note_i etc. after grant SHALL be ignored.
REQ-026 Minimum one snd_en=0 cycle SHALL separate consecutive grants (IDLE or DONE).
REQ-027 Simultaneous requests in IDLE: exactly one gnt bit; losers remain pending with no side effect.
REQ-028 done and err SHALL never assert in the same cycle.

Reset
REQ-029 On rst=1 at clk edge: state IDLE, gnt=0, done=0, err=0, snd_en=0, snd_note/oct/len=0, busy=0, watchdog=0, rr pointer=1.
REQ-030 Reset mid-PLAY SHALL drop snd_en and gnt next edge with no done/err pulse.

Configuration
REQ-031 With macro SND_ARB_PREEMPT_EN defined, req[0] rising while requester 1..3 owns in START/PLAY SHALL abort the owner (no done), insert one IDLE cycle with snd_en=0, then grant requester 0.
REQ-032 Without SND_ARB_PREEMPT_EN, req[0] SHALL wait for the current owner's DONE and then win the next arbitration.

Verification
REQ-033 req=4'b0010, note_i[5:3]=3'd5; snd_over falls cycle+3, rises cycle+20 -> gnt=4'b0010 at +1, snd_note=5, done=4'b0010 one cycle after snd_over rise, then IDLE.
REQ-034 req=4'b1110 held, snd_over modeled per grant -> grant order 1,2,3,1; with req[0] added mid-sequence, 0 wins next arbitration.
REQ-035 Grant, snd_over never falls -> err pulse at ACK_CYCLES, no done, snd_en low next cycle, pointer advanced.
REQ-036 Owner drops req mid-PLAY -> gnt=0, snd_en=0 next edge, no done, pointer unchanged.
REQ-037 With SND_ARB_PREEMPT_EN: requester 2 in PLAY, req[0] raised -> gnt 0 one cycle, then gnt=4'b0001; without macro: requester 2 receives done first.
REQ-038 rst=1 in PLAY -> all outputs zero next edge; after release, pending req[3] granted within 1 cycle.

Source files
------------

// File: rtl/sound_arbiter_if.sv
// Handshake bundle between note requesters, the sound arbiter and the tone generator.
interface sound_arbiter_if;
  logic [3:0]  req;
  logic [11:0] note_i;
  logic [11:0] oct_i;
  logic [11:0] len_i;
  logic        snd_over;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        snd_en;
  logic [2:0]  snd_note;
  logic [2:0]  snd_oct;
  logic [2:0]  snd_len;
  logic        busy;

  modport master (
    output req, note_i, oct_i, len_i, snd_over,
    input  gnt, done, err, snd_en, snd_note, snd_oct, snd_len, busy
  );

  modport slave (
    input  req, note_i, oct_i, len_i, snd_over,
    output gnt, done, err, snd_en, snd_note, snd_oct, snd_len, busy
  );
endinterface

// File: rtl/sound_arbiter.sv
// Grants the tone generator to one of 4 requesters (req0 strict priority, 1..3 round-robin); req->gnt 1 cycle.
// Owner holds until snd_over rises, drops req, or a watchdog fires; SND_ARB_PREEMPT_EN lets req0 preempt.
module sound_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  ACK_CYCLES     = 8'd16
) (
  input logic            clk,
  input logic            rst,
  sound_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_gnt, w_gnt_nxt;
  logic [3:0]  r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_snd_en, w_snd_en_nxt;
  logic [2:0]  r_note, w_note_nxt;
  logic [2:0]  r_oct, w_oct_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic [1:0]  r_own, w_own_nxt;
  logic [1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [7:0]  r_ack_cnt, w_ack_cnt_nxt;
  logic [23:0] r_wd_cnt, w_wd_cnt_nxt;

  logic [1:0]  w_win, w_c0, w_c1, w_c2;
  logic        w_preempt, w_owner_req, w_wd_hit, w_ack_hit;
  logic        w_fin, w_fin_err, w_abort;

  function automatic logic [1:0] f_rr_next(input logic [1:0] idx);
    return (idx == 2'd3) ? 2'd1 : idx + 2'd1;
  endfunction

  always_comb begin
    w_c0  = r_rr_ptr;
    w_c1  = f_rr_next(w_c0);
    w_c2  = f_rr_next(w_c1);
    w_win = 2'd0;
    if (bus.req[0])          w_win = 2'd0;
    else if (bus.req[w_c0])  w_win = w_c0;
    else if (bus.req[w_c1])  w_win = w_c1;
    else if (bus.req[w_c2])  w_win = w_c2;
  end

  assign w_owner_req = bus.req[r_own];
  assign w_wd_hit    = (r_wd_cnt >= TIMEOUT_CYCLES - 24'd1);
  assign w_ack_hit   = (r_ack_cnt >= ACK_CYCLES - 8'd1);

`ifdef SND_ARB_PREEMPT_EN
  logic r_req0_q;
  always_ff @(posedge clk) begin
    if (rst) r_req0_q <= 1'b0;
    else     r_req0_q <= bus.req[0];
  end
  // Only a fresh req0 edge preempts, and never preempts requester 0 itself.
  assign w_preempt = bus.req[0] && !r_req0_q && (r_own != 2'd0);
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = 4'd0;
    w_err_nxt     = 1'b0;
    w_snd_en_nxt  = r_snd_en;
    w_note_nxt    = r_note;
    w_oct_nxt     = r_oct;
    w_len_nxt     = r_len;
    w_own_nxt     = r_own;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_ack_cnt_nxt = r_ack_cnt;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_fin         = 1'b0;
    w_fin_err     = 1'b0;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt   = S_START;
          w_gnt_nxt     = 4'b0001 << w_win;
          w_snd_en_nxt  = 1'b1;
          w_note_nxt    = bus.note_i[3*w_win +: 3];
          w_oct_nxt     = bus.oct_i[3*w_win +: 3];
          w_len_nxt     = bus.len_i[3*w_win +: 3];
          w_own_nxt     = w_win;
          w_ack_cnt_nxt = 8'd0;
          w_wd_cnt_nxt  = 24'd0;
        end
      end
      S_START: begin
        w_wd_cnt_nxt  = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + 24'd1;
        w_ack_cnt_nxt = r_ack_cnt + 8'd1;
        if (!w_owner_req || w_preempt) w_abort = 1'b1;
        else if (!bus.snd_over)        w_state_nxt = S_PLAY;
        else if (w_ack_hit || w_wd_hit) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_PLAY: begin
        w_wd_cnt_nxt = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + 24'd1;
        if (!w_owner_req || w_preempt) w_abort = 1'b1;
        else if (bus.snd_over)         w_fin = 1'b1;
        else if (w_wd_hit) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort leaves the round-robin pointer alone; completion (clean or error) advances it.
    if (w_abort) begin
      w_state_nxt  = S_IDLE;
      w_gnt_nxt    = 4'd0;
      w_snd_en_nxt = 1'b0;
    end
    if (w_fin) begin
      w_state_nxt  = S_DONE;
      w_gnt_nxt    = 4'd0;
      w_snd_en_nxt = 1'b0;
      w_done_nxt   = w_fin_err ? 4'd0 : r_gnt;
      w_err_nxt    = w_fin_err;
      if (r_own != 2'd0) w_rr_ptr_nxt = f_rr_next(r_own);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 4'd0;
      r_done    <= 4'd0;
      r_err     <= 1'b0;
      r_snd_en  <= 1'b0;
      r_note    <= 3'd0;
      r_oct     <= 3'd0;
      r_len     <= 3'd0;
      r_own     <= 2'd0;
      r_rr_ptr  <= 2'd1;
      r_ack_cnt <= 8'd0;
      r_wd_cnt  <= 24'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_snd_en  <= w_snd_en_nxt;
      r_note    <= w_note_nxt;
      r_oct     <= w_oct_nxt;
      r_len     <= w_len_nxt;
      r_own     <= w_own_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_ack_cnt <= w_ack_cnt_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.snd_en   = r_snd_en;
  assign bus.snd_note = r_note;
  assign bus.snd_oct  = r_oct;
  assign bus.snd_len  = r_len;
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboarded bench for sound_arbiter: expected grants are queued at stimulus time and popped as grants appear.
module tb_sound_arbiter;
  localparam int ACK = 8;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sound_arbiter_if bus();

  sound_arbiter #(
    .TIMEOUT_CYCLES(24'(TMO)),
    .ACK_CYCLES    (8'(ACK))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.req = 4'd0;
    bus.snd_over = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int max, output logic [3:0] g, output int lat);
    g = 4'd0;
    lat = 0;
    for (int k = 1; k <= max; k++) begin
      tick;
      if (bus.gnt != 4'd0) begin
        g = bus.gnt;
        lat = k;
        break;
      end
    end
  endtask

  task automatic play_tone(input int fall, input int rise, output logic [3:0] d, output logic e);
    for (int k = 1; k <= rise; k++) begin
      tick;
      if (k == fall) bus.snd_over = 1'b0;
    end
    bus.snd_over = 1'b1;
    tick;
    d = bus.done;
    e = bus.err;
  endtask

  function automatic logic [3:0] pop_exp();
    return (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
  endfunction

  task automatic test_reset;
    logic [3:0] g, exp;
    int lat;
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.snd_over = 1'b1;
    tick;
    tick;
    n_vec++;
    if ({bus.gnt, bus.done, bus.err, bus.snd_en, bus.busy} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h expected 000", {bus.gnt, bus.done, bus.err, bus.snd_en, bus.busy});
    end
    n_vec++;
    if ({bus.snd_note, bus.snd_oct, bus.snd_len} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_fields: got %h expected 000", {bus.snd_note, bus.snd_oct, bus.snd_len});
    end
    rst = 1'b0;
    bus.req = 4'b1110;
    exp_q.push_back(4'b0010);
    wait_grant(2, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp || lat != 1) begin
      n_bad++;
      $display("FAIL reset_rr_start: got gnt %b lat %0d expected gnt %b lat 1", g, lat, exp);
    end
    do_reset;
  endtask

  task automatic test_single;
    logic [3:0] g, d, exp;
    logic e;
    int lat;
    do_reset;
    bus.note_i = {3'd4, 3'd6, 3'd5, 3'd7};
    bus.oct_i  = {3'd1, 3'd2, 3'd3, 3'd4};
    bus.len_i  = {3'd6, 3'd5, 3'd6, 3'd1};
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp || lat != 1 || bus.snd_en !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got gnt %b lat %0d en %b expected gnt %b lat 1 en 1", g, lat, bus.snd_en, exp);
    end
    n_vec++;
    if ({bus.snd_note, bus.snd_oct, bus.snd_len} !== {3'd5, 3'd3, 3'd6}) begin
      n_bad++;
      $display("FAIL single_fields: got %0d/%0d/%0d expected 5/3/6", bus.snd_note, bus.snd_oct, bus.snd_len);
    end
    bus.note_i = 12'hFFF;
    bus.oct_i  = 12'hFFF;
    bus.len_i  = 12'hFFF;
    tick;
    n_vec++;
    if ({bus.snd_note, bus.snd_oct, bus.snd_len} !== {3'd5, 3'd3, 3'd6}) begin
      n_bad++;
      $display("FAIL single_hold: got %0d/%0d/%0d expected 5/3/6", bus.snd_note, bus.snd_oct, bus.snd_len);
    end
    play_tone(1, 18, d, e);
    n_vec++;
    if (d !== 4'b0010 || e !== 1'b0 || bus.gnt !== 4'd0 || bus.snd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got done %b err %b gnt %b en %b expected 0010 0 0000 0", d, e, bus.gnt, bus.snd_en);
    end
    bus.req = 4'd0;
    tick;
    n_vec++;
    if (bus.done !== 4'd0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: got done %b busy %b expected 0000 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g, d, exp;
    logic e;
    int lat;
    do_reset;
    bus.req = 4'b1110;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    for (int i = 0; i < 5; i++) begin
      wait_grant(3, g, lat);
      exp = pop_exp();
      n_vec++;
      if (g !== exp || lat != ((i == 0) ? 1 : 2)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got gnt %b lat %0d expected gnt %b lat %0d", i, g, lat, exp, (i == 0) ? 1 : 2);
      end
      play_tone(2, 5, d, e);
      n_vec++;
      if (d !== exp || e !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_done%0d: got done %b err %b expected %b 0", i, d, e, exp);
      end
    end
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL rr_prio0: got gnt %b expected %b", g, exp);
    end
    play_tone(2, 5, d, e);
    n_vec++;
    if (d !== 4'b0001) begin
      n_bad++;
      $display("FAIL rr_prio0_done: got done %b expected 0001", d);
    end
    do_reset;
  endtask

  task automatic test_ack_timeout;
    logic [3:0] g, exp;
    int lat, hit;
    do_reset;
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL ack_grant: got gnt %b expected %b", g, exp);
    end
    hit = 0;
    for (int k = 1; k <= ACK + 4; k++) begin
      tick;
      if (bus.err || bus.done != 4'd0) begin
        hit = k;
        break;
      end
    end
    n_vec++;
    if (hit != ACK || bus.err !== 1'b1 || bus.done !== 4'd0 || bus.snd_en !== 1'b0 || bus.gnt !== 4'd0) begin
      n_bad++;
      $display("FAIL ack_err: got cycles %0d err %b done %b en %b expected %0d 1 0000 0", hit, bus.err, bus.done, bus.snd_en, ACK);
    end
    bus.req = 4'b1010;
    exp_q.push_back(4'b1000);
    tick;
    n_vec++;
    if (bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_err_pulse: got err %b expected 0", bus.err);
    end
    wait_grant(2, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL ack_ptr_adv: got gnt %b expected %b", g, exp);
    end
    do_reset;
  endtask

  task automatic test_watchdog;
    logic [3:0] g, exp;
    int lat, hit;
    do_reset;
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL wd_grant: got gnt %b expected %b", g, exp);
    end
    hit = 0;
    for (int k = 1; k <= TMO + 4; k++) begin
      tick;
      if (bus.err || bus.done != 4'd0) begin
        hit = k;
        break;
      end
      if (k == 2) bus.snd_over = 1'b0;
    end
    n_vec++;
    if (hit != TMO || bus.err !== 1'b1 || bus.done !== 4'd0 || bus.snd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_err: got cycles %0d err %b done %b en %b expected %0d 1 0000 0", hit, bus.err, bus.done, bus.snd_en, TMO);
    end
    bus.snd_over = 1'b1;
    bus.req = 4'd0;
    tick;
    n_vec++;
    if (bus.err !== 1'b0 || bus.done !== 4'd0) begin
      n_bad++;
      $display("FAIL wd_pulse: got err %b done %b expected 0 0000", bus.err, bus.done);
    end
    do_reset;
  endtask

  task automatic test_abort;
    logic [3:0] g, exp;
    int lat;
    do_reset;
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(3, g, lat);
    exp = pop_exp();
    tick;
    bus.snd_over = 1'b0;
    tick;
    tick;
    bus.req = 4'd0;
    tick;
    n_vec++;
    if ({bus.gnt, bus.snd_en, bus.done, bus.err, bus.busy} !== 11'd0) begin
      n_bad++;
      $display("FAIL abort_drop: got %h expected 000", {bus.gnt, bus.snd_en, bus.done, bus.err, bus.busy});
    end
    bus.snd_over = 1'b1;
    bus.req = 4'b0110;
    exp_q.push_back(4'b0010);
    wait_grant(2, g, lat);
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL abort_first: got gnt %b expected %b", g, exp);
    end
    exp = pop_exp();
    n_vec++;
    if (g !== exp || lat != 1) begin
      n_bad++;
      $display("FAIL abort_ptr_kept: got gnt %b lat %0d expected %b lat 1", g, lat, exp);
    end
    do_reset;
  endtask

  task automatic test_preempt;
    logic [3:0] g, exp;
    int lat;
    do_reset;
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL pre_grant: got gnt %b expected %b", g, exp);
    end
    tick;
    bus.snd_over = 1'b0;
    tick;
    tick;
    bus.req = 4'b0101;
`ifdef SND_ARB_PREEMPT_EN
    tick;
    n_vec++;
    if (bus.gnt !== 4'd0 || bus.snd_en !== 1'b0 || bus.done !== 4'd0) begin
      n_bad++;
      $display("FAIL pre_gap: got gnt %b en %b done %b expected 0000 0 0000", bus.gnt, bus.snd_en, bus.done);
    end
    bus.snd_over = 1'b1;
    exp_q.push_back(4'b0001);
    wait_grant(1, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp) begin
      n_bad++;
      $display("FAIL pre_win0: got gnt %b expected %b", g, exp);
    end
`else
    tick;
    n_vec++;
    if (bus.gnt !== 4'b0100 || bus.snd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_hold: got gnt %b en %b expected 0100 1", bus.gnt, bus.snd_en);
    end
    bus.snd_over = 1'b1;
    tick;
    n_vec++;
    if (bus.done !== 4'b0100) begin
      n_bad++;
      $display("FAIL pre_done2: got done %b expected 0100", bus.done);
    end
    exp_q.push_back(4'b0001);
    wait_grant(3, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp || lat != 2) begin
      n_bad++;
      $display("FAIL pre_win0: got gnt %b lat %0d expected %b lat 2", g, lat, exp);
    end
`endif
    do_reset;
  endtask

  task automatic test_reset_mid_play;
    logic [3:0] g, exp;
    int lat;
    do_reset;
    bus.req = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_grant(3, g, lat);
    exp = pop_exp();
    tick;
    bus.snd_over = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    n_vec++;
    if ({bus.gnt, bus.snd_en, bus.done, bus.err, bus.busy, bus.snd_note, bus.snd_oct, bus.snd_len} !== 20'd0) begin
      n_bad++;
      $display("FAIL rst_play: got %h expected 00000",
               {bus.gnt, bus.snd_en, bus.done, bus.err, bus.busy, bus.snd_note, bus.snd_oct, bus.snd_len});
    end
    rst = 1'b0;
    bus.snd_over = 1'b1;
    exp_q.push_back(4'b1000);
    wait_grant(1, g, lat);
    exp = pop_exp();
    n_vec++;
    if (g !== exp || lat != 1) begin
      n_bad++;
      $display("FAIL rst_regrant: got gnt %b lat %0d expected %b lat 1", g, lat, exp);
    end
    do_reset;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 4'd0;
    bus.note_i = 12'd0;
    bus.oct_i = 12'd0;
    bus.len_i = 12'd0;
    bus.snd_over = 1'b1;
    test_reset;
    test_single;
    test_round_robin;
    test_ack_timeout;
    test_watchdog;
    test_abort;
    test_preempt;
    test_reset_mid_play;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
